// File: rtl/fifo_mp_if.sv
// fifo_mp_if: bus bundle between a multi-port FIFO and the logic around it.
//   master : producer/consumer side; drives flush, push_cnt, dinp, pop_cnt
//   slave  : FIFO side; drives src_num_avail, doup, doup_vld,
//            dst_num_avail, overflow, underflow
// Lane k of the packed dinp/doup vectors occupies bits [k*WIDTH +: WIDTH];
// lane 0 is the oldest entry.
interface fifo_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int HEADS = 2,
    parameter int TAILS = 2
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(HEADS) + 1;
    localparam int TW = $clog2(TAILS) + 1;

    logic                   flush;
    logic [HW-1:0]          push_cnt;
    logic [HEADS*WIDTH-1:0] dinp;
    logic [CW-1:0]          src_num_avail;
    logic [TW-1:0]          pop_cnt;
    logic [TAILS*WIDTH-1:0] doup;
    logic [TAILS-1:0]       doup_vld;
    logic [CW-1:0]          dst_num_avail;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output flush, push_cnt, dinp, pop_cnt,
        input  src_num_avail, doup, doup_vld, dst_num_avail, overflow, underflow
    );

    modport slave (
        input  flush, push_cnt, dinp, pop_cnt,
        output src_num_avail, doup, doup_vld, dst_num_avail, overflow, underflow
    );
endinterface

// File: rtl/fifo_mp.sv
// fifo_mp: single-clock multi-port FIFO. Accepts up to HEADS entries and
// retires up to TAILS entries per cycle, all-or-nothing on each side.
// Output lanes are show-ahead: doup lane i is the entry i places behind the
// read pointer, zeroed when that entry does not exist.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset; empties the FIFO and zeroes storage
//   bus  : fifo_mp_if slave modport
//          flush          - synchronous empty, clears sticky flags
//          push_cnt/dinp  - lanes 0..push_cnt-1 are written this cycle
//          pop_cnt        - entries retired this cycle
//          doup/doup_vld  - show-ahead output lanes
//          src/dst_num_avail - free / occupied entry counts
//          overflow/underflow - sticky rejected-push / rejected-pop flags
// All outputs decode from registered state only.
module fifo_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int HEADS = 2,
    parameter int TAILS = 2
) (
    input  logic      clk,
    input  logic      rst,
    fifo_mp_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;  // count width, holds 0..DEPTH
    localparam int PW = CW - 1;             // pointer width, wraps modulo DEPTH
    localparam int XW = CW + 1;             // headroom for acceptance arithmetic

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_mp: DEPTH must be a power of 2 and at least 2");
    end
    if ((HEADS < 1) || (HEADS > DEPTH)) begin : g_bad_heads
        $error("fifo_mp: HEADS must be in 1..DEPTH");
    end
    if ((TAILS < 1) || (TAILS > DEPTH)) begin : g_bad_tails
        $error("fifo_mp: TAILS must be in 1..DEPTH");
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [XW-1:0]    push_n, pop_n, used_n, free_n;
    logic             push_ok, pop_ok, push_rej, pop_rej;

    // Acceptance looks only at the registered count: a same-cycle pop never
    // makes room for a push, and a same-cycle push is never poppable.
    always_comb begin
        push_n   = XW'(bus.push_cnt);
        pop_n    = XW'(bus.pop_cnt);
        used_n   = XW'(count_q);
        free_n   = XW'(DEPTH) - used_n;
        push_ok  = (push_n <= XW'(HEADS)) && (push_n <= free_n);
        pop_ok   = (pop_n <= XW'(TAILS)) && (pop_n <= used_n);
        push_rej = (push_n != '0) && !push_ok;
        pop_rej  = (pop_n != '0) && !pop_ok;
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // path through the branches below can leave one unassigned (latch).
        data_d      = data_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            // Flush drops same-cycle push/pop silently; storage is kept.
            rptr_d      = '0;
            wptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                for (int i = 0; i < HEADS; i++) begin
                    if (XW'(i) < push_n) begin
                        data_d[PW'(wptr_q + PW'(i))] = bus.dinp[i*WIDTH +: WIDTH];
                    end
                end
                wptr_d = PW'(wptr_q + PW'(push_n));
            end
            if (pop_ok) begin
                rptr_d = PW'(rptr_q + PW'(pop_n));
            end
            count_d = CW'(used_n + (push_ok ? push_n : '0) - (pop_ok ? pop_n : '0));
            overflow_d  = overflow_q  | push_rej;
            underflow_d = underflow_q | pop_rej;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            // NOTE: storage is cleared on reset so lanes can never expose
            // power-up contents; this makes the array flops with reset rather
            // than a plain RAM.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            data_q      <= data_d;
        end
    end

    // Show-ahead lanes: invalid lanes are forced to zero, never stale data.
    always_comb begin
        bus.doup     = '0;
        bus.doup_vld = '0;
        for (int i = 0; i < TAILS; i++) begin
            if (CW'(i) < count_q) begin
                bus.doup_vld[i]               = 1'b1;
                bus.doup[i*WIDTH +: WIDTH]    = data_q[PW'(rptr_q + PW'(i))];
            end
        end
    end

    assign bus.src_num_avail = CW'(DEPTH) - count_q;
    assign bus.dst_num_avail = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_fifo_mp.sv
// tb_fifo_mp: directed bench for fifo_mp at WIDTH=8, DEPTH=8, HEADS=2,
// TAILS=2. Each step drives one cycle of inputs and queues the hand-computed
// state expected after that edge; a monitor on the falling edge pops each
// expectation and compares it against the DUT outputs.
module tb_fifo_mp;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int HEADS = 2;
    localparam int TAILS = 2;

    typedef struct {
        string       name;
        int          dst;
        logic [1:0]  vld;
        logic [15:0] doup;
        logic        ov;
        logic        un;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t mon_e;

    fifo_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HEADS(HEADS), .TAILS(TAILS)) bus ();

    fifo_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HEADS(HEADS), .TAILS(TAILS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the state left by the most recent edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, ".dst"}, 32'(bus.dst_num_avail), 32'(mon_e.dst));
            check({mon_e.name, ".src"}, 32'(bus.src_num_avail), 32'(DEPTH - mon_e.dst));
            check({mon_e.name, ".vld"}, 32'(bus.doup_vld), 32'(mon_e.vld));
            check({mon_e.name, ".doup"}, 32'(bus.doup), 32'(mon_e.doup));
            check({mon_e.name, ".ovf"}, 32'(bus.overflow), 32'(mon_e.ov));
            check({mon_e.name, ".unf"}, 32'(bus.underflow), 32'(mon_e.un));
        end
    end

    // One clock of stimulus; the expectation describes the state after it.
    task automatic step(input string nm, input logic r, input logic fl,
                        input logic [1:0] pc, input logic [15:0] din,
                        input logic [1:0] oc, input int e_dst,
                        input logic [1:0] e_vld, input logic [15:0] e_doup,
                        input logic e_ov, input logic e_un);
        exp_t e;
        rst          = r;
        bus.flush    = fl;
        bus.push_cnt = pc;
        bus.dinp     = din;
        bus.pop_cnt  = oc;
        @(posedge clk);
        e.name = nm;
        e.dst  = e_dst;
        e.vld  = e_vld;
        e.doup = e_doup;
        e.ov   = e_ov;
        e.un   = e_un;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.push_cnt = '0;
        bus.dinp     = '0;
        bus.pop_cnt  = '0;
        @(negedge clk);

        //    name            rst  fl  push  dinp       pop  dst vld    doup       ov    un
        step("reset0",        1, 0, 2'd2, 16'hFFEE, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
        step("reset1",        1, 0, 2'd2, 16'hFFEE, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
        // push and show-ahead
        step("push_a01",      0, 0, 2'd2, 16'hA1A0, 2'd0, 2, 2'b11, 16'hA1A0, 0, 0);
        step("push_a23",      0, 0, 2'd2, 16'hA3A2, 2'd0, 4, 2'b11, 16'hA1A0, 0, 0);
        step("pop_a01",       0, 0, 2'd0, 16'h0000, 2'd2, 2, 2'b11, 16'hA3A2, 0, 0);
        step("pop_a23",       0, 0, 2'd0, 16'h0000, 2'd2, 0, 2'b00, 16'h0000, 0, 0);
        // fill to full (indices 4..7, 0..3), then push+pop at full
        step("fill0",         0, 0, 2'd2, 16'h1110, 2'd0, 2, 2'b11, 16'h1110, 0, 0);
        step("fill1",         0, 0, 2'd2, 16'h1312, 2'd0, 4, 2'b11, 16'h1110, 0, 0);
        step("fill2",         0, 0, 2'd2, 16'h1514, 2'd0, 6, 2'b11, 16'h1110, 0, 0);
        step("fill3",         0, 0, 2'd2, 16'h1716, 2'd0, 8, 2'b11, 16'h1110, 0, 0);
        step("full_pushpop",  0, 0, 2'd1, 16'h00EE, 2'd1, 7, 2'b11, 16'h1211, 1, 0);
        step("ovf_sticky",    0, 0, 2'd0, 16'h0000, 2'd0, 7, 2'b11, 16'h1211, 1, 0);
        step("push_no_room",  0, 0, 2'd2, 16'h3433, 2'd0, 7, 2'b11, 16'h1211, 1, 0);
        step("flush_full",    0, 1, 2'd2, 16'h4443, 2'd1, 0, 2'b00, 16'h0000, 0, 0);
        // walk pointers to 7 with concurrent push/pop, then wrap
        step("walk0",         0, 0, 2'd2, 16'hE1E0, 2'd0, 2, 2'b11, 16'hE1E0, 0, 0);
        step("walk1",         0, 0, 2'd2, 16'hE3E2, 2'd2, 2, 2'b11, 16'hE3E2, 0, 0);
        step("walk2",         0, 0, 2'd2, 16'hE5E4, 2'd2, 2, 2'b11, 16'hE5E4, 0, 0);
        step("walk3",         0, 0, 2'd1, 16'h77E6, 2'd2, 1, 2'b01, 16'h00E6, 0, 0);
        step("walk4",         0, 0, 2'd0, 16'h0000, 2'd1, 0, 2'b00, 16'h0000, 0, 0);
        step("wrap_push",     0, 0, 2'd2, 16'hB1B0, 2'd0, 2, 2'b11, 16'hB1B0, 0, 0);
        step("wrap_pop",      0, 0, 2'd0, 16'h0000, 2'd2, 0, 2'b00, 16'h0000, 0, 0);
        // underflow
        step("one_entry",     0, 0, 2'd1, 16'h55F0, 2'd0, 1, 2'b01, 16'h00F0, 0, 0);
        step("pop2_of_1",     0, 0, 2'd0, 16'h0000, 2'd2, 1, 2'b01, 16'h00F0, 0, 1);
        step("pop3_over",     0, 0, 2'd0, 16'h0000, 2'd3, 1, 2'b01, 16'h00F0, 0, 1);
        step("pop_last",      0, 0, 2'd0, 16'h0000, 2'd1, 0, 2'b00, 16'h0000, 0, 1);
        step("empty_pushpop", 0, 0, 2'd1, 16'h339A, 2'd1, 1, 2'b01, 16'h009A, 0, 1);
        // flush versus push, then fresh push
        step("flush_push",    0, 1, 2'd2, 16'h6665, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
        step("push_c0",       0, 0, 2'd1, 16'h99C0, 2'd0, 1, 2'b01, 16'h00C0, 0, 0);
        step("push_c12",      0, 0, 2'd2, 16'h2120, 2'd0, 3, 2'b11, 16'h20C0, 0, 0);
        // reset mid-stream, then push wider than HEADS
        step("rst_mid",       1, 0, 2'd2, 16'h7776, 2'd1, 0, 2'b00, 16'h0000, 0, 0);
        step("push3_over",    0, 0, 2'd3, 16'hFFFF, 2'd0, 0, 2'b00, 16'h0000, 1, 0);
        step("idle_end",      0, 0, 2'd0, 16'h0000, 2'd0, 0, 2'b00, 16'h0000, 1, 0);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_mp.md
# fifo_mp

Multi-port synchronous FIFO: next generation of the single-clock shift-register FIFO. Accepts up to HEADS entries and retires up to TAILS entries per cycle, with show-ahead output lanes, all-or-nothing push/pop acceptance, sticky overflow/underflow flags and a synchronous flush. It sits between the fetch/decode front end and multi-issue consumers, where several entries move per clock.

## Interface
- WIDTH, 32, bits per entry
- DEPTH, 16, number of entries; power of 2, ≥ 2 (elaboration `$error` otherwise)
- HEADS, 2, push lanes; 1 ≤ HEADS ≤ DEPTH
- TAILS, 2, pop/output lanes; 1 ≤ TAILS ≤ DEPTH
- Derived: CW = $clog2(DEPTH)+1, the count width; HW = $clog2(HEADS)+1; TW = $clog2(TAILS)+1

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous empty of the FIFO
- push_cnt  in  HW  number of lanes to push this cycle; lanes 0..push_cnt-1 of dinp are valid
- dinp  in  HEADS×WIDTH  packed push data; lane 0 is oldest
- src_num_avail  out  CW  free entries
- pop_cnt  in  TW  number of entries to retire this cycle
- doup  out  TAILS×WIDTH  show-ahead data; lane i = entry at read position + i
- doup_vld  out  TAILS  lane i valid ⇔ i < dst_num_avail
- dst_num_avail  out  CW  occupied entries
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- State: data[DEPTH] of WIDTH bits, rptr and wptr of CW−1 bits (wrap modulo DEPTH), count of CW bits (0..DEPTH inclusive).
- src_num_avail = DEPTH − count, dst_num_avail = count, both decoded from registered state.
- Push acceptance: push_ok = (push_cnt ≤ HEADS) && (push_cnt ≤ src_num_avail). Evaluated against the current-cycle count only; a same-cycle pop does not free space for it.
- If push_ok: data[(wptr+i) mod DEPTH] ← dinp[i] for i < push_cnt; wptr ← wptr + push_cnt.
- If push_cnt ≠ 0 and !push_ok: nothing is written, wptr is unchanged, overflow ← 1. A partial push never occurs.
- Pop acceptance: pop_ok = (pop_cnt ≤ TAILS) && (pop_cnt ≤ dst_num_avail), against the current-cycle count only. A same-cycle push cannot be popped.
- If pop_ok: rptr ← rptr + pop_cnt. If pop_cnt ≠ 0 and !pop_ok: no change, underflow ← 1.
- count ← count + (push_ok ? push_cnt : 0) − (pop_ok ? pop_cnt : 0); never leaves 0..DEPTH.
- doup[i] = data[(rptr+i) mod DEPTH] when doup_vld[i] = 1, else 0. Invalid lanes never show stale data.
- Priority: rst > flush > push/pop.
- flush: rptr, wptr and count ← 0; overflow and underflow ← 0. Same-cycle push and pop are ignored and set no flags. Data array is not cleared.
- rst: everything flush does, plus all data entries ← 0.

## Timing
- Reset values: src_num_avail = DEPTH, dst_num_avail = 0, doup_vld = 0, doup = 0, overflow = 0, underflow = 0.
- Push-to-visible latency: one cycle. Data pushed at edge N appears on doup and is counted in dst_num_avail after edge N.
- Pop is immediate. Lanes shift after the edge on which pop_cnt is accepted; the next entry is on doup[0] in the following cycle.
- doup and doup_vld are combinational from registered state only. There is no combinational path from push_cnt, pop_cnt or dinp to any output.
- Wrap-around: pointer arithmetic is modulo DEPTH. Multi-lane writes and reads that straddle index DEPTH−1 → 0 are contiguous.
- Full (count = DEPTH): any push_cnt > 0 is rejected, even with a same-cycle pop.
- Empty (count = 0): any pop_cnt > 0 is rejected, even with a same-cycle push.
- rst or flush asserted mid-stream takes effect on that edge; the FIFO is empty in the following cycle.

## Test plan
Use WIDTH=8, DEPTH=8, HEADS=2, TAILS=2 unless noted.
- Reset: hold rst for 2 cycles with push_cnt=2 → src_num_avail=8, dst_num_avail=0, doup_vld=00, doup=0, flags 0.
- Push and show-ahead: push_cnt=2 with {A1,A0}, next cycle {A3,A2} → dst=4, doup[0]=A0, doup[1]=A1, vld=11. Then pop_cnt=2 → doup[0]=A2, doup[1]=A3, dst=2.
- Full and overflow: fill 8 entries, then push_cnt=1 with pop_cnt=1 → push rejected, pop accepted, overflow=1, dst=7, src=1. overflow stays 1 until flush.
- Wrap-around: with rptr=wptr=7, push {B1,B0} → B0 at index 7, B1 at index 0. Pop 2 → returns B0 then B1; dst=0.
- Underflow: with 1 entry, pop_cnt=2 → no change, dst=1, doup_vld=01, underflow=1.
- Flush versus push: flush=1 with push_cnt=2 → dst=0 and flags cleared next cycle. Then push C0 → doup[0]=C0 after one cycle, vld=01.
